// File: rtl/apb_coll_regs.sv
// apb_coll_regs: APB3 control, status and per-channel snapshot registers for a collector.
// Define COLL_IRQ_EN to add the IRQ_EN register at 0x08 and the registered Irq output.
module apb_coll_regs #(
    parameter int NUM_CH     = 3,
    parameter int DATA_SIZE  = 4,
    parameter int LENGTH_ADD = 5
) (
    input  logic                           FCLK_CLK1,
    input  logic                           rstn,
    input  logic [31:0]                    APB_M_0_paddr,
    input  logic                           APB_M_0_psel,
    input  logic                           APB_M_0_penable,
    input  logic                           APB_M_0_pwrite,
    input  logic [31:0]                    APB_M_0_pwdata,
    output logic [31:0]                    APB_M_0_prdata,
    output logic                           APB_M_0_pready,
    output logic                           APB_M_0_pslverr,
    output logic                           StartColl,
    input  logic                           CollDone,
    input  logic [NUM_CH*DATA_SIZE-1:0]    MaxCountData,
    input  logic [NUM_CH*LENGTH_ADD-1:0]   MaxCount,
    output logic                           Irq
);

    typedef enum logic [1:0] {
        S_BLOCK,
        S_IDLE,
        S_ACK
    } state_t;

    state_t state, state_nxt;

    logic [31:0] prdata_q;
    logic        pslverr_q;

    logic        start, start_nxt;
    logic        oneshot, oneshot_nxt;
    logic        busy, busy_nxt;
    logic        done, done_nxt;
    logic        irq_en_bit;

    logic [NUM_CH-1:0][DATA_SIZE-1:0]  ch_data;
    logic [NUM_CH-1:0][LENGTH_ADD-1:0] ch_cnt;

    logic [5:0]  word;
    logic        acc;
    logic        aligned;
    logic        hit_ctrl, hit_stat, hit_irq, hit_ch;
    logic        err;
    logic        commit;
    logic        wr_ctrl, wr_stat, wr_irq;
    logic [31:0] ch_word;
    logic [31:0] rd_data;
    logic        unused_bits;

    assign unused_bits = ^{APB_M_0_paddr[31:8], APB_M_0_pwdata[31:2]};

    always_comb begin
        word     = APB_M_0_paddr[7:2];
        aligned  = APB_M_0_paddr[1:0] == 2'b00;
        hit_ctrl = word == 6'd0;
        hit_stat = word == 6'd1;
`ifdef COLL_IRQ_EN
        hit_irq  = word == 6'd2;
`else
        hit_irq  = 1'b0;
`endif
        hit_ch   = 1'b0;
        ch_word  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (word == 6'(4 + i)) begin
                hit_ch  = 1'b1;
                ch_word = {16'(ch_data[i]), 16'(ch_cnt[i])};
            end
        end
        // STATUS bit0 is read-only: writing a 1 there is rejected
        err = !aligned
            || !(hit_ctrl || hit_stat || hit_irq || hit_ch)
            || (APB_M_0_pwrite && (hit_ch || (hit_stat && APB_M_0_pwdata[0])));
        rd_data = '0;
        unique case (1'b1)
            hit_ctrl: rd_data = {30'b0, oneshot, start};
            hit_stat: rd_data = {30'b0, done, busy};
            hit_irq:  rd_data = {31'b0, irq_en_bit};
            hit_ch:   rd_data = ch_word;
            default:  rd_data = '0;
        endcase
    end

    always_comb begin
        acc       = APB_M_0_psel && APB_M_0_penable;
        state_nxt = state;
        unique case (state)
            S_BLOCK: if (!acc) state_nxt = S_IDLE;
            S_IDLE:  if (acc)  state_nxt = S_ACK;
            S_ACK:   state_nxt = S_IDLE;
            default: state_nxt = S_BLOCK;
        endcase
        commit  = (state == S_ACK) && acc && APB_M_0_pwrite && !pslverr_q;
        wr_ctrl = commit && hit_ctrl;
        wr_stat = commit && hit_stat;
        wr_irq  = commit && hit_irq;
    end

    always_ff @(posedge FCLK_CLK1 or negedge rstn) begin
        if (!rstn) begin
            state     <= S_BLOCK;
            prdata_q  <= '0;
            pslverr_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == S_IDLE && acc) begin
                prdata_q  <= (!APB_M_0_pwrite && !err) ? rd_data : '0;
                pslverr_q <= err;
            end else begin
                prdata_q  <= '0;
                pslverr_q <= 1'b0;
            end
        end
    end

    always_comb begin
        start_nxt   = start;
        oneshot_nxt = oneshot;
        if (oneshot && start)
            start_nxt = 1'b0;
        if (wr_ctrl) begin
            start_nxt   = APB_M_0_pwdata[0];
            oneshot_nxt = APB_M_0_pwdata[1];
        end
        busy_nxt = busy;
        if (CollDone)
            busy_nxt = 1'b0;
        if (start_nxt && !start)
            busy_nxt = 1'b1;
        done_nxt = CollDone || (done && !(wr_stat && APB_M_0_pwdata[1]));
    end

    always_ff @(posedge FCLK_CLK1 or negedge rstn) begin
        if (!rstn) begin
            start   <= 1'b0;
            oneshot <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            ch_data <= '0;
            ch_cnt  <= '0;
        end else begin
            start   <= start_nxt;
            oneshot <= oneshot_nxt;
            busy    <= busy_nxt;
            done    <= done_nxt;
            if (CollDone) begin
                ch_data <= MaxCountData;
                ch_cnt  <= MaxCount;
            end
        end
    end

`ifdef COLL_IRQ_EN
    logic irq_en_q, irq_q;

    always_ff @(posedge FCLK_CLK1 or negedge rstn) begin
        if (!rstn) begin
            irq_en_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            if (wr_irq)
                irq_en_q <= APB_M_0_pwdata[0];
            irq_q <= done && irq_en_q;
        end
    end

    assign irq_en_bit = irq_en_q;
    assign Irq        = irq_q;
`else
    logic unused_irq;

    assign unused_irq = wr_irq;
    assign irq_en_bit = 1'b0;
    assign Irq        = 1'b0;
`endif

    assign APB_M_0_prdata  = prdata_q;
    assign APB_M_0_pready  = state == S_ACK;
    assign APB_M_0_pslverr = pslverr_q;
    assign StartColl       = start;

endmodule

// File: doc/apb_coll_regs.md
APB_COLL_REGS -- requirements
Module: apb_coll_regs

Interface
REQ-001 Parameter NUM_CH, default 3: number of collector channels, legal range 1..8.
REQ-002 Parameter DATA_SIZE, default 4: width of each MaxCountData field, legal range 1..16.
REQ-003 Parameter LENGTH_ADD, default 5: width of each MaxCount field, legal range 1..16.
REQ-004 Port FCLK_CLK1  in  1  clock; all logic is rising-edge triggered.
REQ-005 Port rstn  in  1  reset: asynchronous, active-low.
REQ-006 Ports APB_M_0_paddr in 32, APB_M_0_psel in 1, APB_M_0_penable in 1, APB_M_0_pwrite in 1, APB_M_0_pwdata in 32: APB3 requester side.
REQ-007 Ports APB_M_0_prdata out 32, APB_M_0_pready out 1, APB_M_0_pslverr out 1: APB3 completer response.
REQ-008 Port StartColl  out  1  collector run enable.
REQ-009 Port CollDone  in  1  single-cycle pulse marking end of a collection run.
REQ-010 Port MaxCountData  in  NUM_CH*DATA_SIZE  channel i in bits [i*DATA_SIZE +: DATA_SIZE].
REQ-011 Port MaxCount  in  NUM_CH*LENGTH_ADD  channel i in bits [i*LENGTH_ADD +: LENGTH_ADD].
REQ-012 Port Irq  out  1  level interrupt.

Function
REQ-013 Register map decodes paddr[7:0]: 0x00 CTRL, 0x04 STATUS, 0x08 IRQ_EN, 0x10+4*i CH_i for i in 0..NUM_CH-1.
REQ-014 CTRL: bit0 START rw, bit1 ONESHOT rw; other bits read 0.
REQ-015 StartColl shall equal CTRL.START.
REQ-016 With ONESHOT=1 and START=1, START shall clear on the clock edge after it is observed set (one-cycle StartColl pulse); a START write on that same edge wins.
REQ-017 STATUS: bit0 BUSY read-only, set by a START rising edge and cleared by CollDone; bit1 DONE sticky, set by CollDone, cleared by writing 1 (W1C).
REQ-018 If CollDone and a DONE W1C occur on the same edge, DONE shall remain 1.
REQ-019 On CollDone, all channels shall be snapshotted into CH registers in the same cycle; CH_i reads {zero-pad, data_i} in [31:16] and {zero-pad, count_i} in [15:0].
REQ-020 CH registers hold their snapshot until the next CollDone; they are not live.
REQ-021 APB timing: the first cycle with psel=1 and penable=1 is a wait state (pready=0); pready=1 on the following cycle; pready=0 on the cycle after that, so every access takes exactly one wait state.
REQ-022 A write commits on the cycle pready=1; prdata is registered and valid on the cycle pready=1, and reads 0 otherwise.
REQ-023 pslverr shall be 1 only when pready=1, for: unmapped offset, paddr[1:0]!=0, or a write to STATUS bit0 / CH registers; erroneous writes shall change no state.
REQ-024 Writes to STATUS with bit1=0 shall be legal and have no effect.
REQ-025 psel dropped before pready returns to the wait state: the access is abandoned with no write commit.

Reset
REQ-026 On rstn low: CTRL=0, STATUS=0, IRQ_EN=0, all CH=0, prdata=0, pready=0, pslverr=0, Irq=0, StartColl=0.
REQ-027 Reset asserted mid-access aborts it; after release, the block waits for a fresh psel&penable.

Configuration
REQ-028 Macro COLL_IRQ_EN defined: IRQ_EN bit0 rw at 0x08; Irq = STATUS.DONE & IRQ_EN[0], registered with one-cycle latency.
REQ-029 Macro COLL_IRQ_EN undefined: offset 0x08 is unmapped (pslverr); Irq is tied to 0; no IRQ_EN flop.

Verification
REQ-030 Write 0x1 to 0x00 -> pready high on the 2nd penable cycle, pslverr=0; StartColl=1 next cycle; read 0x04 = 0x1.
REQ-031 Write 0x3 to 0x00 -> StartColl high for exactly 1 cycle; read 0x00 = 0x2.
REQ-032 NUM_CH=3, channel 2 inputs data=0xA, count=0x13, CollDone pulse, then inputs change -> read 0x18 = 0x000A0013; read 0x04 = 0x2.
REQ-033 DONE set, W1C of 0x2 to 0x04 coincident with CollDone -> DONE remains 1; W1C alone -> read 0x04 = 0x0.
REQ-034 Read 0x1C with NUM_CH=3, read 0x02, write 0x10 -> each returns pslverr=1 with pready; CH_0 unchanged.
REQ-035 COLL_IRQ_EN defined: write 0x1 to 0x08, CollDone -> Irq=1 one cycle after DONE sets; W1C DONE -> Irq=0; undefined build: Irq stays 0 and 0x08 gives pslverr=1.
